// File: rtl/window_streamer.sv
// Raster-scan column-window generator: buffers K rows in a circular line store
// and emits one K-tall pixel column per output position, top/bottom borders resolved here.
module window_streamer #(
  parameter int BIT_LENGTH = 5,
  parameter int IMG_W      = 20,
  parameter int IMG_H      = 20,
  parameter int K          = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    border_mode,
  input  logic [BIT_LENGTH-1:0]   pixel_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [K*BIT_LENGTH-1:0] window_col,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_col_first,
  output logic                    out_col_last,
  output logic                    out_frame_end,
  output logic                    busy
);

  localparam int H         = (K - 1) / 2;
  localparam int N         = IMG_W * IMG_H;
  localparam int CW        = $clog2(N + 1);
  localparam int RW        = $clog2(IMG_H + K + 1);
  localparam int XW        = $clog2(IMG_W);
  localparam int SW        = $clog2(K);
  localparam int LAST_SLOT = (IMG_H - 1) % K;

  // Slot holding row (j-H) at the start of a frame, with negative rows wrapped.
  function automatic logic [SW-1:0] slot_init(input int j);
    if (j >= H) begin
      return SW'(j - H);
    end else begin
      return SW'(j - H + K);
    end
  endfunction

  logic [BIT_LENGTH-1:0]   mem_r [K][IMG_W];

  logic [CW-1:0]           in_cnt_r, in_cnt_nx;
  logic [CW-1:0]           out_cnt_r, out_cnt_nx;
  logic [RW-1:0]           ri_r, ri_nx, lr_r, lr_nx;
  logic [XW-1:0]           ci_r, ci_nx, lc_r, lc_nx;
  logic [SW-1:0]           wslot_r, wslot_nx;
  logic [SW-1:0]           sl_r [K];
  logic [SW-1:0]           sl_nx [K];
  logic                    bmode_r;
  logic                    in_ready_r, ready_nx;
  logic                    out_valid_r, first_r, last_r, fe_r, busy_r;
  logic [K*BIT_LENGTH-1:0] window_col_r, col_s;

  logic                    acc_s, ld_s, end_s, elig_s;
  logic [RW-1:0]           nr_s;
  logic                    top_s [K];
  logic                    bot_s [K];
  logic [SW-1:0]           slot_s [K];

  assign in_ready      = in_ready_r & ~reset;
  assign window_col    = window_col_r;
  assign out_valid     = out_valid_r;
  assign out_col_first = first_r;
  assign out_col_last  = last_r;
  assign out_frame_end = fe_r;
  assign busy          = busy_r;

  // Handshakes and eligibility of the next position to load (last input row it needs).
  always_comb begin
    acc_s = in_valid & in_ready;
    end_s = out_valid_r & out_ready & fe_r;
    if ((lr_r + RW'(H)) > RW'(IMG_H - 1)) begin
      nr_s = RW'(IMG_H - 1);
    end else begin
      nr_s = lr_r + RW'(H);
    end
    elig_s = (out_cnt_r < CW'(N)) &&
             ((ri_r > nr_s) || ((ri_r == nr_s) && (ci_r > lc_r)));
    ld_s   = elig_s & (~out_valid_r | out_ready);
  end

  // Column read: each window row picks its slot, clamped or zeroed outside the image.
  always_comb begin
    col_s = '0;
    for (int j = 0; j < K; j++) begin
      top_s[j] = (lr_r + RW'(j)) < RW'(H);
      bot_s[j] = (lr_r + RW'(j)) > RW'(IMG_H - 1 + H);
      if (top_s[j]) begin
        slot_s[j] = '0;
      end else if (bot_s[j]) begin
        slot_s[j] = SW'(LAST_SLOT);
      end else begin
        slot_s[j] = sl_r[j];
      end
      if (bmode_r && (top_s[j] || bot_s[j])) begin
        col_s[j*BIT_LENGTH +: BIT_LENGTH] = '0;
      end else begin
        col_s[j*BIT_LENGTH +: BIT_LENGTH] = mem_r[slot_s[j]][lc_r];
      end
    end
  end

  // Next-state of the input and output position counters.
  always_comb begin
    in_cnt_nx  = in_cnt_r;
    ri_nx      = ri_r;
    ci_nx      = ci_r;
    wslot_nx   = wslot_r;
    out_cnt_nx = out_cnt_r;
    lr_nx      = lr_r;
    lc_nx      = lc_r;
    sl_nx      = sl_r;
    if (end_s) begin
      in_cnt_nx  = '0;
      ri_nx      = '0;
      ci_nx      = '0;
      wslot_nx   = '0;
      out_cnt_nx = '0;
      lr_nx      = '0;
      lc_nx      = '0;
      for (int j = 0; j < K; j++) begin
        sl_nx[j] = slot_init(j);
      end
    end else begin
      if (acc_s) begin
        in_cnt_nx = in_cnt_r + CW'(1);
        if (ci_r == XW'(IMG_W - 1)) begin
          ci_nx    = '0;
          ri_nx    = ri_r + RW'(1);
          wslot_nx = (wslot_r == SW'(K - 1)) ? '0 : wslot_r + SW'(1);
        end else begin
          ci_nx = ci_r + XW'(1);
        end
      end else begin
        in_cnt_nx = in_cnt_r;
      end
      if (ld_s) begin
        out_cnt_nx = out_cnt_r + CW'(1);
        if (lc_r == XW'(IMG_W - 1)) begin
          lc_nx = '0;
          lr_nx = lr_r + RW'(1);
          for (int j = 0; j < K; j++) begin
            sl_nx[j] = (sl_r[j] == SW'(K - 1)) ? '0 : sl_r[j] + SW'(1);
          end
        end else begin
          lc_nx = lc_r + XW'(1);
        end
      end else begin
        out_cnt_nx = out_cnt_r;
      end
    end
    // Row ri may overwrite row ri-K only once output (ri-K+H, ci) has been read.
    ready_nx = (in_cnt_nx < CW'(N)) &&
               (((lr_nx + RW'(K - H)) > ri_nx) ||
                (((lr_nx + RW'(K - H)) == ri_nx) && (lc_nx > ci_nx)));
  end

  // Line store write; contents survive reset.
  always_ff @(posedge clk) begin
    if (acc_s) begin
      mem_r[wslot_r][ci_r] <= pixel_in;
    end
  end

  // Counters, ready, frame state and the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt_r     <= '0;
      out_cnt_r    <= '0;
      ri_r         <= '0;
      ci_r         <= '0;
      lr_r         <= '0;
      lc_r         <= '0;
      wslot_r      <= '0;
      for (int j = 0; j < K; j++) begin
        sl_r[j] <= slot_init(j);
      end
      bmode_r      <= 1'b0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      window_col_r <= '0;
      first_r      <= 1'b0;
      last_r       <= 1'b0;
      fe_r         <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      in_cnt_r   <= in_cnt_nx;
      out_cnt_r  <= out_cnt_nx;
      ri_r       <= ri_nx;
      ci_r       <= ci_nx;
      lr_r       <= lr_nx;
      lc_r       <= lc_nx;
      wslot_r    <= wslot_nx;
      sl_r       <= sl_nx;
      in_ready_r <= ready_nx;
      if (acc_s && (in_cnt_r == '0)) begin
        bmode_r <= border_mode;
      end
      if (ld_s) begin
        out_valid_r  <= 1'b1;
        window_col_r <= col_s;
        first_r      <= (lc_r == '0);
        last_r       <= (lc_r == XW'(IMG_W - 1));
        fe_r         <= (lc_r == XW'(IMG_W - 1)) && (lr_r == RW'(IMG_H - 1));
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
      if (end_s) begin
        busy_r <= 1'b0;
      end else if (acc_s) begin
        busy_r <= 1'b1;
      end
    end
  end

endmodule
